alu_op_sequencer: RTL

- Initiator side of the ALU datapath interface: takes one decoded ALU instruction and steps the register-file bus, Y register, Z register (ZHI/ZLO) and HI/LO registers through the operand-load, compute and writeback cycles the ALU requires.
- Drives the ALU's 5-bit op_code and all bus/latch strobes; the ALU itself stays purely combinational.
- Sits between the instruction decoder (start/done handshake) and the datapath.

---
 rtl/alu_op_sequencer_pkg.sv | 45 ++++
 rtl/alu_op_sequencer_if.sv | 48 ++++
 rtl/alu_op_sequencer_classify.sv | 34 +++
 rtl/alu_op_sequencer.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU operation sequencer: the ALU opcode
// encodings, the sequencer state enum and the opcode-class enum.
// Optional feature macro: ALU_MULDIV_EN (consumed by alu_op_classify and
// alu_op_sequencer; nothing here depends on it).
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam int OPW_DEF  = 5;
    localparam int REGW_DEF = 4;

    // ALU opcode encodings
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LD_Y  = 3'd1,
        S_LD_Z  = 3'd2,
        S_WB_LO = 3'd3,
        S_WB_HI = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    // BINARY is encoding 0 so a reset latched class reads as all-zero
    typedef enum logic [1:0] {
        CLS_BINARY  = 2'd0,
        CLS_MULDIV  = 2'd1,
        CLS_UNARY   = 2'd2,
        CLS_ILLEGAL = 2'd3
    } op_class_e;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// ----------------------------------------------------------------------------
// alu_op_sequencer_if
// Bundles the decoder handshake (start, op_in, ra, rb, rc / busy, done,
// illegal) and the datapath strobes driven toward the ALU, register file,
// Y, Z (ZHI/ZLO) and HI/LO registers.
//   master : the sequencer (consumes the request, drives all strobes)
//   slave  : the decoder/datapath side
// Optional feature macro: ALU_MULDIV_EN (no effect on this file).
// ----------------------------------------------------------------------------
interface alu_op_sequencer_if #(
    parameter int OPW  = 5,
    parameter int REGW = 4
);

    logic            start;
    logic [OPW-1:0]  op_in;
    logic [REGW-1:0] ra;
    logic [REGW-1:0] rb;
    logic [REGW-1:0] rc;

    logic            busy;
    logic            done;
    logic            illegal;
    logic [OPW-1:0]  alu_op;
    logic            r_out_en;
    logic [REGW-1:0] r_out_sel;
    logic            y_in;
    logic            z_in;
    logic            zlo_out;
    logic            zhi_out;
    logic            r_in_en;
    logic [REGW-1:0] r_in_sel;
    logic            lo_in;
    logic            hi_in;

    modport master (
        input  start, op_in, ra, rb, rc,
        output busy, done, illegal, alu_op, r_out_en, r_out_sel, y_in, z_in,
               zlo_out, zhi_out, r_in_en, r_in_sel, lo_in, hi_in
    );

    modport slave (
        output start, op_in, ra, rb, rc,
        input  busy, done, illegal, alu_op, r_out_en, r_out_sel, y_in, z_in,
               zlo_out, zhi_out, r_in_en, r_in_sel, lo_in, hi_in
    );

endinterface

// File: rtl/alu_op_sequencer_classify.sv
// ----------------------------------------------------------------------------
// alu_op_classify
// Combinational opcode-to-class decoder.
//   op_i  : ALU opcode
//   cls_o : BINARY, MULDIV, UNARY or ILLEGAL
// Optional feature macro: ALU_MULDIV_EN. When undefined, mul/div decode
// as ILLEGAL.
// ----------------------------------------------------------------------------
module alu_op_classify
    import alu_pkg::*;
#(
    parameter int OPW = 5
) (
    input  logic [OPW-1:0] op_i,
    output op_class_e      cls_o
);

    // Every opcode not listed is unsupported
    always_comb begin
        cls_o = CLS_ILLEGAL;
        case (op_i)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL:      cls_o = CLS_BINARY;
            OP_NEG, OP_NOT:                        cls_o = CLS_UNARY;
`ifdef ALU_MULDIV_EN
            OP_MUL, OP_DIV:                        cls_o = CLS_MULDIV;
`else
            OP_MUL, OP_DIV:                        cls_o = CLS_ILLEGAL;
`endif
            default:                               cls_o = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// ----------------------------------------------------------------------------
// alu_op_sequencer
// Steps one decoded ALU instruction through operand load (Y), compute (Z)
// and writeback (GPR or LO/HI), driving the ALU op_code and every bus and
// latch strobe.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus_if : alu_op_sequencer_if.master (start/op_in/ra/rb/rc in;
//            busy/done/illegal and datapath strobes out)
// Optional feature macro: ALU_MULDIV_EN. When undefined, mul/div finish
// as illegal, WB_HI is never entered and lo_in/hi_in stay 0.
// ----------------------------------------------------------------------------
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int OPW  = 5,
    parameter int REGW = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_op_sequencer_if.master    bus_if
);

    state_e          state_q, state_d;
    op_class_e       cls_q, cls_d, cls_w;
    logic [OPW-1:0]  op_q, op_d;
    logic [REGW-1:0] ra_q, ra_d;
    logic [REGW-1:0] rb_q, rb_d;
    logic [REGW-1:0] rc_q, rc_d;

    alu_op_classify #(.OPW(OPW)) u_classify (
        .op_i  (bus_if.op_in),
        .cls_o (cls_w)
    );

    // State and latched instruction fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cls_q   <= CLS_BINARY;
            op_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            rc_q    <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            op_q    <= op_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rc_q    <= rc_d;
        end
    end

    // Next state; fields are captured only when a request is accepted in IDLE
    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        op_d    = op_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rc_d    = rc_q;
        case (state_q)
            S_IDLE: begin
                if (bus_if.start) begin
                    cls_d = cls_w;
                    op_d  = bus_if.op_in;
                    ra_d  = bus_if.ra;
                    rb_d  = bus_if.rb;
                    rc_d  = bus_if.rc;
                    case (cls_w)
                        CLS_BINARY, CLS_MULDIV: state_d = S_LD_Y;
                        CLS_UNARY:              state_d = S_LD_Z;
                        default:                state_d = S_DONE;
                    endcase
                end
            end
            S_LD_Y:  state_d = S_LD_Z;
            S_LD_Z:  state_d = S_WB_LO;
`ifdef ALU_MULDIV_EN
            S_WB_LO: state_d = (cls_q == CLS_MULDIV) ? S_WB_HI : S_DONE;
`else
            S_WB_LO: state_d = S_DONE;
`endif
            S_WB_HI: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes decode from state and latched fields only; at most one bus
    // driver (r_out_en, zlo_out, zhi_out) is active in any state
    always_comb begin
        bus_if.busy      = (state_q != S_IDLE);
        bus_if.done      = 1'b0;
        bus_if.illegal   = 1'b0;
        bus_if.alu_op    = '0;
        bus_if.r_out_en  = 1'b0;
        bus_if.r_out_sel = '0;
        bus_if.y_in      = 1'b0;
        bus_if.z_in      = 1'b0;
        bus_if.zlo_out   = 1'b0;
        bus_if.zhi_out   = 1'b0;
        bus_if.r_in_en   = 1'b0;
        bus_if.r_in_sel  = '0;
        bus_if.lo_in     = 1'b0;
        bus_if.hi_in     = 1'b0;
        case (state_q)
            S_LD_Y: begin
                bus_if.r_out_en  = 1'b1;
                bus_if.r_out_sel = (cls_q == CLS_MULDIV) ? ra_q : rb_q;
                bus_if.y_in      = 1'b1;
            end
            S_LD_Z: begin
                bus_if.r_out_en  = 1'b1;
                bus_if.r_out_sel = (cls_q == CLS_BINARY) ? rc_q : rb_q;
                bus_if.z_in      = 1'b1;
                bus_if.alu_op    = op_q;
            end
            S_WB_LO: begin
                bus_if.zlo_out = 1'b1;
`ifdef ALU_MULDIV_EN
                if (cls_q == CLS_MULDIV) begin
                    bus_if.lo_in = 1'b1;
                end else begin
                    bus_if.r_in_en  = 1'b1;
                    bus_if.r_in_sel = ra_q;
                end
`else
                bus_if.r_in_en  = 1'b1;
                bus_if.r_in_sel = ra_q;
`endif
            end
            S_WB_HI: begin
                bus_if.zhi_out = 1'b1;
`ifdef ALU_MULDIV_EN
                bus_if.hi_in   = 1'b1;
`endif
            end
            S_DONE: begin
                bus_if.done    = 1'b1;
                bus_if.illegal = (cls_q == CLS_ILLEGAL);
            end
            default: ;
        endcase
    end

endmodule
